// File: rtl/mod_exp_seq_pkg.sv
// mod_exp_pkg: shared FSM state type and exponent MSB priority encoder
package mod_exp_pkg;
  localparam int EXP_W = 64;
  localparam int MSB_W = $clog2(EXP_W);

  typedef enum logic [2:0] {IDLE, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, DONE} state_t;

  function automatic logic [MSB_W-1:0] msb_idx(input logic [EXP_W-1:0] e);
    msb_idx = '0;
    for (int i = 0; i < EXP_W; i++) if (e[i]) msb_idx = MSB_W'(i);
  endfunction
endpackage

// File: rtl/mod_exp_seq_if.sv
// mod_exp_seq_if: host request/result and multiplier val/rdy channels
interface mod_exp_seq_if #(parameter int BITS = 392, parameter int EXP_BITS = 64);
  logic                i_val;
  logic                o_rdy;
  logic [BITS-1:0]     i_base;
  logic [EXP_BITS-1:0] i_exp;
  logic                o_val;
  logic                i_rdy;
  logic [BITS-1:0]     o_dat;
  logic                o_busy;
  logic                o_mul_val;
  logic                i_mul_rdy;
  logic [BITS-1:0]     o_mul_a;
  logic [BITS-1:0]     o_mul_b;
  logic                i_mul_val;
  logic                o_mul_rdy;
  logic [BITS-1:0]     i_mul_dat;

  modport slave (
    input  i_val, i_base, i_exp, i_rdy, i_mul_rdy, i_mul_val, i_mul_dat,
    output o_rdy, o_val, o_dat, o_busy, o_mul_val, o_mul_a, o_mul_b, o_mul_rdy
  );

  modport master (
    output i_val, i_base, i_exp, i_rdy, i_mul_rdy, i_mul_val, i_mul_dat,
    input  o_rdy, o_val, o_dat, o_busy, o_mul_val, o_mul_a, o_mul_b, o_mul_rdy
  );
endinterface

// File: rtl/mod_exp_seq.sv
// mod_exp_seq: left-to-right square-and-multiply sequencer driving an external modular multiplier
module mod_exp_seq
  import mod_exp_pkg::*;
#(
  parameter int BITS     = 392,
  parameter int EXP_BITS = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  mod_exp_seq_if.slave b
);
  state_t              state_q;
  logic [BITS-1:0]     acc_q, base_q, dat_q, mul_b_q;
  logic [EXP_BITS-1:0] exp_q;
  logic [MSB_W-1:0]    idx_q, msb_d, idx_d;
  logic                rdy_q, val_q, busy_q, mul_val_q, mul_rdy_q;

  // acc doubles as multiplier operand A: it always holds the value being squared or multiplied
  assign b.o_rdy     = rdy_q;
  assign b.o_val     = val_q;
  assign b.o_dat     = dat_q;
  assign b.o_busy    = busy_q;
  assign b.o_mul_val = mul_val_q;
  assign b.o_mul_a   = acc_q;
  assign b.o_mul_b   = mul_b_q;
  assign b.o_mul_rdy = mul_rdy_q;

  // leading-one position of the incoming exponent and the next lower bit index
  always_comb begin
    msb_d = msb_idx(EXP_W'(b.i_exp));
    idx_d = idx_q - 1'b1;
  end

  // sequencer FSM; every output is set on entry to the state that presents it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      dat_q     <= '0;
      mul_b_q   <= '0;
      idx_q     <= '0;
      rdy_q     <= 1'b1;
      val_q     <= 1'b0;
      busy_q    <= 1'b0;
      mul_val_q <= 1'b0;
      mul_rdy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (b.i_val) begin
          base_q <= b.i_base;
          exp_q  <= b.i_exp;
          rdy_q  <= 1'b0;
          busy_q <= 1'b1;
          if (b.i_exp < EXP_BITS'(2)) begin
            acc_q   <= b.i_exp[0] ? b.i_base : BITS'(1);
            dat_q   <= b.i_exp[0] ? b.i_base : BITS'(1);
            val_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            acc_q     <= b.i_base;
            mul_b_q   <= b.i_base;
            idx_q     <= msb_d - 1'b1;
            mul_val_q <= 1'b1;
            state_q   <= SQR_REQ;
          end
        end
        SQR_REQ: if (b.i_mul_rdy) begin
          mul_val_q <= 1'b0;
          mul_rdy_q <= 1'b1;
          state_q   <= SQR_WAIT;
        end
        SQR_WAIT: if (b.i_mul_val) begin
          acc_q     <= b.i_mul_dat;
          mul_rdy_q <= 1'b0;
          if (exp_q[idx_q]) begin
            mul_b_q   <= base_q;
            mul_val_q <= 1'b1;
            state_q   <= MUL_REQ;
          end else if (idx_q == '0) begin
            dat_q   <= b.i_mul_dat;
            val_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q     <= idx_d;
            mul_b_q   <= b.i_mul_dat;
            mul_val_q <= 1'b1;
            state_q   <= SQR_REQ;
          end
        end
        MUL_REQ: if (b.i_mul_rdy) begin
          mul_val_q <= 1'b0;
          mul_rdy_q <= 1'b1;
          state_q   <= MUL_WAIT;
        end
        MUL_WAIT: if (b.i_mul_val) begin
          acc_q     <= b.i_mul_dat;
          mul_rdy_q <= 1'b0;
          if (idx_q == '0) begin
            dat_q   <= b.i_mul_dat;
            val_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q     <= idx_d;
            mul_b_q   <= b.i_mul_dat;
            mul_val_q <= 1'b1;
            state_q   <= SQR_REQ;
          end
        end
        DONE: if (b.i_rdy) begin
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mod_exp_seq.sv
// tb_mod_exp_seq: scoreboard bench with a behavioural mod-65521 multiplier and a pow-mod reference
module tb_mod_exp_seq;
  localparam int BITS = 16;
  localparam int EB   = 64;
  localparam longint MOD = 65521;

  logic clk = 0;
  logic rst_n;
  always #5 clk = ~clk;

  mod_exp_seq_if #(.BITS(BITS), .EXP_BITS(EB)) b();
  mod_exp_seq #(.BITS(BITS), .EXP_BITS(EB)) dut (.i_clk(clk), .i_rst_n(rst_n), .b(b));

  int total = 0, bad = 0;
  bit stall = 0, hold_rdy = 0;
  int req_total = 0;
  logic [BITS-1:0] expq[$];
  int cntq[$];
  logic [31:0] reqlog[$];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, act, want);
    end
  endtask

  function automatic longint pow_ref(input longint base, input logic [63:0] e);
    longint r = 1, x = base % MOD;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % MOD;
      x = (x * x) % MOD;
    end
    return r;
  endfunction

  function automatic int mul_count(input logic [63:0] e);
    int m = 0;
    if (e < 2) return 0;
    for (int i = 0; i < 64; i++) if (e[i]) m = i;
    return m + $countones(e) - 1;
  endfunction

  // behavioural multiplier: random accept stalls, random 1-8 cycle latency
  initial begin
    int cnt;
    bit busy = 0, rq = 0, rs = 0;
    logic [BITS-1:0] res = 0;
    b.i_mul_rdy = 0; b.i_mul_val = 0; b.i_mul_dat = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 0; rq = 0; rs = 0; b.i_mul_val = 0; b.i_mul_rdy = 0; req_total = 0;
        continue;
      end
      if (rs) begin b.i_mul_val = 0; busy = 0; end
      if (rq) begin busy = 1; cnt = $urandom_range(1, 8); end
      if (busy && !b.i_mul_val) begin
        cnt--;
        if (cnt == 0) begin b.i_mul_val = 1; b.i_mul_dat = res; end
      end
      b.i_mul_rdy = !busy && !stall && ($urandom_range(0, 3) != 0);
      rq = b.i_mul_rdy && b.o_mul_val;
      rs = b.i_mul_val && b.o_mul_rdy;
      if (rq) begin
        res = BITS'((longint'(b.o_mul_a) * longint'(b.o_mul_b)) % MOD);
        reqlog.push_back({b.o_mul_a, b.o_mul_b});
        req_total++;
      end
    end
  end

  // result monitor: random consumer ready, scoreboard pop on handshake, hold stability
  initial begin
    int last = 0;
    bit have_prev = 0;
    logic [BITS-1:0] prev = 0;
    b.i_rdy = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin last = 0; have_prev = 0; b.i_rdy = 0; continue; end
      if (have_prev) chk("dat_stable", b.o_dat, prev);
      b.i_rdy = hold_rdy ? 1'b0 : 1'($urandom_range(0, 1));
      if (b.o_val && b.i_rdy) begin
        chk("result_expected", expq.size() != 0, 1);
        if (expq.size() != 0) begin
          chk("result", b.o_dat, expq.pop_front());
          chk("mul_count", req_total - last, cntq.pop_front());
        end
        last = req_total;
      end
      have_prev = b.o_val && !b.i_rdy;
      prev = b.o_dat;
    end
  end

  task automatic send(input logic [BITS-1:0] base, input logic [63:0] e);
    int n = 0;
    while (!b.o_rdy && n < 20000) begin @(negedge clk); n++; end
    chk("rdy_wait", b.o_rdy, 1);
    b.i_val = 1; b.i_base = base; b.i_exp = e;
    expq.push_back(BITS'(pow_ref(longint'(base), e)));
    cntq.push_back(mul_count(e));
    @(negedge clk);
    b.i_val = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(expq.size() == 0 && b.o_rdy) && n < 20000) begin @(negedge clk); n++; end
    chk("idle_wait", expq.size() == 0 && b.o_rdy, 1);
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_rdy"}, b.o_rdy, 1);
    chk({n, "_val"}, b.o_val, 0);
    chk({n, "_busy"}, b.o_busy, 0);
    chk({n, "_mval"}, b.o_mul_val, 0);
    chk({n, "_mrdy"}, b.o_mul_rdy, 0);
    chk({n, "_dat"}, b.o_dat, 0);
    chk({n, "_ma"}, b.o_mul_a, 0);
    chk({n, "_mb"}, b.o_mul_b, 0);
  endtask

  initial begin
    logic [31:0] ops13 [5] = '{{16'd3, 16'd3}, {16'd9, 16'd3}, {16'd27, 16'd27},
                               {16'd729, 16'd729}, {16'd7273, 16'd3}};
    logic [BITS-1:0] d;
    logic [63:0] e;
    int n;
    rst_n = 0; b.i_val = 0; b.i_base = 0; b.i_exp = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1;
    @(negedge clk);

    reqlog.delete();
    send(3, 0);
    chk("e0_latency", b.o_val, 1);
    wait_idle();
    chk("e0_nreq", reqlog.size(), 0);

    reqlog.delete();
    send(3, 1);
    chk("e1_latency", b.o_val, 1);
    wait_idle();
    chk("e1_nreq", reqlog.size(), 0);

    reqlog.delete();
    stall = 1;
    send(3, 13);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mval", b.o_mul_val, 1);
      chk("stall_ma", b.o_mul_a, 3);
      chk("stall_mb", b.o_mul_b, 3);
      chk("stall_busy", b.o_busy, 1);
      @(negedge clk);
    end
    stall = 0;
    wait_idle();
    chk("e13_nreq", reqlog.size(), 5);
    for (int i = 0; i < 5; i++) if (i < reqlog.size()) chk("e13_op", reqlog[i], ops13[i]);

    hold_rdy = 1;
    send(11, 5);
    n = 0;
    while (!b.o_val && n < 20000) begin @(negedge clk); n++; end
    chk("done_wait", b.o_val, 1);
    d = b.o_dat;
    for (int i = 0; i < 3; i++) begin
      chk("hold_dat", b.o_dat, d);
      chk("hold_rdy", b.o_rdy, 0);
      b.i_val = 1; b.i_base = 1; b.i_exp = 0;
      @(negedge clk);
    end
    b.i_val = 0;
    hold_rdy = 0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("ignored_ival", b.o_busy, 0);

    send(7, 100);
    n = 0;
    while (!b.o_mul_rdy && n < 2000) begin @(negedge clk); n++; end
    chk("reach_wait", b.o_mul_rdy, 1);
    rst_n = 0;
    #1;
    chk_reset_vals("midrst");
    expq.delete(); cntq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send(5, 2);
    wait_idle();

    for (int k = 0; k < 14; k++) begin
      e = {$urandom, $urandom};
      e = e >> $urandom_range(0, 63);
      send(BITS'($urandom_range(0, 65520)), e);
    end
    wait_idle();

    reqlog.delete();
    send(BITS'($urandom_range(0, 65520)), 64'hFFFF_FFFF_FFFF_FFFF);
    wait_idle();
    chk("ones_nreq", reqlog.size(), 126);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
